pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: cycles to drain EX/MEM/WB after an ECALL leaves ID; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port dmem_busy, input, 1: data memory is stalling the pipeline this cycle.
REQ-005 SHALL have port branch_taken_EX, input, 1: branch or jump resolved taken in EX.
REQ-006 SHALL have port ecall_ID, input, 1: ECALL present in ID (ECALL_IFID_IDEX).
REQ-007 SHALL have port load_use_ID, input, 1: instruction in ID needs rd of a load in EX.
REQ-008 SHALL have port resume, input, 1: ECALL serviced, restart fetch.
REQ-009 SHALL have port pc_hold, output, 1: PC register does not update.
REQ-010 SHALL have port ifid_stall, output, 1: IF/ID holds its contents.
REQ-011 SHALL have port ifid_flush, output, 1: IF/ID loads NOP_INSTR_HEX.
REQ-012 SHALL have port idex_flush, output, 1: ID/EX loads a bubble.
REQ-013 SHALL have port pipe_freeze, output, 1: all pipeline registers hold.
REQ-014 SHALL have port halted, output, 1: pipeline drained and waiting for resume.
REQ-015 SHALL have port stall_cnt, output, 32: cycles with pc_hold=1.
REQ-016 SHALL have port flush_cnt, output, 32: branch-flush events.

Function
REQ-017 SHALL implement FSM states RUN, DRAIN, HALT, plus a 1-bit bubble_done flag and a 4-bit drain counter.
REQ-018 SHALL drive all outputs combinationally from state, flag and inputs in the same cycle (zero latency).
REQ-019 SHALL, in any state with dmem_busy=1: assert pipe_freeze, pc_hold and ifid_stall; suppress all other actions; hold state and counter.
REQ-020 SHALL, in RUN with branch_taken_EX=1 (priority below dmem_busy): assert ifid_flush and idex_flush for that cycle, ignore ecall_ID and load_use_ID, clear bubble_done, and stay in RUN.
REQ-021 SHALL, in RUN with ecall_ID=1 (next priority): assert pc_hold and ifid_flush, load counter with DRAIN_CYCLES-1, and move to DRAIN.
REQ-022 SHALL, in RUN with load_use_ID=1 and bubble_done=0 (lowest priority): assert pc_hold, ifid_stall and idex_flush, and set bubble_done.
REQ-023 SHALL clear bubble_done on any RUN cycle where load_use_ID=0; a load-use hazard therefore inserts exactly one bubble even if load_use_ID stays high.
REQ-024 SHALL, in DRAIN: assert pc_hold and ifid_flush; decrement the counter each non-frozen cycle; move to HALT on the cycle the counter reads 0.
REQ-025 SHALL, in HALT: assert halted, pc_hold and ifid_flush; ignore ecall_ID, branch_taken_EX and load_use_ID; move to RUN on resume=1 with no output change that cycle.
REQ-026 SHALL ignore resume outside HALT.
REQ-027 SHALL increment stall_cnt on each pc_hold cycle and flush_cnt on each REQ-020 event; both saturate at 0xFFFFFFFF.

Reset
REQ-028 SHALL, on rst=1 at a clk edge: set state to RUN, bubble_done to 0, drain counter to 0, and stall_cnt/flush_cnt to 0.
REQ-029 SHALL hold all combinational outputs at 0 while rst=1, with reset taking priority over every input.
REQ-030 SHALL abandon DRAIN or HALT entirely on a mid-operation reset.

Configuration
REQ-031 SHALL include the stall_cnt/flush_cnt registers and their increment logic when PIPE_CTRL_PERF_EN is defined.
REQ-032 SHALL, without PIPE_CTRL_PERF_EN: keep the ports, tie stall_cnt and flush_cnt to 0, and leave all other behaviour identical.

Structure
REQ-033 SHALL take the state enum pipe_ctrl_state_t (RUN/DRAIN/HALT) and NOP_INSTR_HEX from common_def.
REQ-034 SHALL place the counters in one sub-module, pipe_perf_counters, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-035 SHALL cover: load_use_ID high 3 cycles -> pc_hold/ifid_stall/idex_flush high in cycle 1 only; stall_cnt=1.
REQ-036 SHALL cover: branch_taken_EX and load_use_ID and ecall_ID together -> only ifid_flush/idex_flush; state RUN; flush_cnt=1.
REQ-037 SHALL cover: ecall_ID pulse, DRAIN_CYCLES=3 -> DRAIN 3 cycles, then halted=1; resume 5 cycles later -> RUN next cycle; stall_cnt=9.
REQ-038 SHALL cover: dmem_busy high 2 cycles mid-DRAIN -> pipe_freeze=1, counter frozen; HALT entry delayed by exactly 2 cycles.
REQ-039 SHALL cover: rst=1 during HALT -> next cycle state RUN, halted=0, counters 0.
REQ-040 SHALL cover: build without PIPE_CTRL_PERF_EN, repeat REQ-035 -> identical control outputs; stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state type,
// the NOP encoding loaded into IF/ID on a flush, the control-output bundle
// and a saturating increment used by the performance counters.
package common_def;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic pc_hold;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
        logic halted;
    } pipe_ctrl_out_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_counters.sv
// pipe_perf_counters: stall-cycle and branch-flush event counters,
// both saturating at 0xFFFFFFFF and cleared by synchronous reset.
import common_def::*;

module pipe_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Next-count: bump each counter on its event, saturating.
    always_comb begin
        stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_inc ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: zero-latency stall/flush/freeze control for a 5-stage
// pipeline. Handles data-memory freeze, taken-branch flush, ECALL drain and
// halt, and single-bubble load-use interlock.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall/flush counters;
// without it the counter ports read 0.
import common_def::*;

module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_busy,
    input  logic        branch_taken_EX,
    input  logic        ecall_ID,
    input  logic        load_use_ID,
    input  logic        resume,
    output logic        pc_hold,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_freeze,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    pipe_ctrl_state_t state_q, state_d;
    logic             bubble_done_q, bubble_done_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    pipe_ctrl_out_t   ctl;

    // Priority decode: reset > dmem freeze > branch > ecall > load-use.
    always_comb begin
        state_d       = state_q;
        bubble_done_d = bubble_done_q;
        drain_cnt_d   = drain_cnt_q;
        ctl           = '0;
        if (rst) begin
            // outputs forced low; registers are cleared in the flop block
        end else if (dmem_busy) begin
            ctl.pipe_freeze = 1'b1;
            ctl.pc_hold     = 1'b1;
            ctl.ifid_stall  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken_EX) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                        bubble_done_d  = 1'b0;
                    end else if (ecall_ID) begin
                        ctl.pc_hold    = 1'b1;
                        ctl.ifid_flush = 1'b1;
                        drain_cnt_d    = DRAIN_LOAD;
                        bubble_done_d  = 1'b0;
                        state_d        = DRAIN;
                    end else if (load_use_ID && !bubble_done_q) begin
                        ctl.pc_hold    = 1'b1;
                        ctl.ifid_stall = 1'b1;
                        ctl.idex_flush = 1'b1;
                        bubble_done_d  = 1'b1;
                    end else if (!load_use_ID) begin
                        bubble_done_d  = 1'b0;
                    end
                end
                DRAIN: begin
                    ctl.pc_hold    = 1'b1;
                    ctl.ifid_flush = 1'b1;
                    if (drain_cnt_q == 4'd0) state_d = HALT;
                    else                     drain_cnt_d = drain_cnt_q - 4'd1;
                end
                HALT: begin
                    ctl.halted     = 1'b1;
                    ctl.pc_hold    = 1'b1;
                    ctl.ifid_flush = 1'b1;
                    if (resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, bubble flag and drain counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            bubble_done_q <= 1'b0;
            drain_cnt_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            bubble_done_q <= bubble_done_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    assign pc_hold     = ctl.pc_hold;
    assign ifid_stall  = ctl.ifid_stall;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign pipe_freeze = ctl.pipe_freeze;
    assign halted      = ctl.halted;

`ifdef PIPE_CTRL_PERF_EN
    // A branch flush is the only case that flushes both IF/ID and ID/EX.
    pipe_perf_counters u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (ctl.pc_hold),
        .flush_inc (ctl.ifid_flush & ctl.idex_flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized stimulus, all checked against a behavioural model that tracks
// mode, remaining drain cycles and the one-bubble rule.
module tb_pipe_hazard_ctrl;

    localparam int DC = 3;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, dmem_busy, branch_taken_EX, ecall_ID, load_use_ID, resume;
    logic pc_hold, ifid_stall, ifid_flush, idex_flush, pipe_freeze, halted;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .dmem_busy(dmem_busy),
        .branch_taken_EX(branch_taken_EX), .ecall_ID(ecall_ID),
        .load_use_ID(load_use_ID), .resume(resume),
        .pc_hold(pc_hold), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=running, 1=draining, 2=halted.
    int          m_mode = 0;
    int          m_left = 0;   // drain cycles still to spend
    bit          m_bub  = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0;
    bit          m_known = 1'b0;

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // One clock cycle: drive at negedge, check 1ns later, advance model.
    task automatic step(input bit r, input bit b, input bit br, input bit ec,
                        input bit lu, input bit rs);
        bit ph, st, ff, xf, fz, hl, fl_evt;
        rst = r; dmem_busy = b; branch_taken_EX = br; ecall_ID = ec;
        load_use_ID = lu; resume = rs;
        #1;
        {ph, st, ff, xf, fz, hl} = '0;
        fl_evt = 1'b0;
        if (r) begin
        end else if (b) begin
            fz = 1; ph = 1; st = 1;
        end else if (m_mode == 0) begin
            if (br)                 begin ff = 1; xf = 1; fl_evt = 1; end
            else if (ec)            begin ph = 1; ff = 1; end
            else if (lu && !m_bub)  begin ph = 1; st = 1; xf = 1; end
        end else if (m_mode == 1) begin
            ph = 1; ff = 1;
        end else begin
            hl = 1; ph = 1; ff = 1;
        end
        check("ctl", {26'd0, pc_hold, ifid_stall, ifid_flush, idex_flush, pipe_freeze, halted},
                     {26'd0, ph, st, ff, xf, fz, hl});
        if (m_known) begin
            check("stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
            check("flush_cnt", flush_cnt, PERF ? m_flush : 32'd0);
        end
        // advance model
        if (r) begin
            m_mode = 0; m_left = 0; m_bub = 0; m_stall = 0; m_flush = 0; m_known = 1;
        end else if (!b) begin
            if (m_mode == 0) begin
                if (br)               m_bub = 0;
                else if (ec)          begin m_mode = 1; m_left = DC; m_bub = 0; end
                else if (lu && !m_bub) m_bub = 1;
                else if (!lu)         m_bub = 0;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end else if (rs) begin
                m_mode = 0;
            end
        end
        if (!r) begin
            if (ph)     m_stall = sat1(m_stall);
            if (fl_evt) m_flush = sat1(m_flush);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        {rst, dmem_busy, branch_taken_EX, ecall_ID, load_use_ID, resume} = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);   // reset wins over every input
        check("rst_stall", stall_cnt, 32'd0);

        // load-use held for 3 cycles: one bubble only
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);
        check("lu_stall", stall_cnt, PERF ? 32'd1 : 32'd0);

        // branch + load-use + ecall together: only the branch flush
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0);
        idle(1);
        check("br_flush", flush_cnt, PERF ? 32'd1 : 32'd0);
        check("br_run", {31'd0, pc_hold}, 32'd0);

        // ecall: 3 drain cycles, halt, resume 5 cycles in
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0);
        check("halt_entry", {31'd0, halted}, 32'd1);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        check("ecall_stall", stall_cnt, PERF ? 32'd9 : 32'd0);
        check("resumed", {31'd0, halted}, 32'd0);

        // dmem freeze mid-drain delays halt by 2 cycles
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0);
        check("frz_halt", {31'd0, halted}, 32'd1);

        // reset during halt
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        check("rst_halt", {31'd0, halted}, 32'd0);
        check("rst_cnt", stall_cnt | flush_cnt, 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
